// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth sequencing controller.
// Optional feature macro: BOOTH_ZERO_SKIP_EN (see booth_seq_ctrl.sv).
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARITH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } op_e;

    // Width needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Radix-2 Booth recoding of the {Q[0], Q-1} pair.
    function automatic op_e decode_op(input logic q0, input logic qm1);
        op_e op;
        case ({q0, qm1})
            2'b10:   op = SUB;
            2'b01:   op = ADD;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Loadable down-counter holding the remaining Booth iterations.
// Clear and load have priority over decrement; reset is asynchronous active-low.
module booth_iter_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    logic [W-1:0] cnt_r;

    // Iteration count register: clear, reload, or step down by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign is_one = (cnt_r == W'(1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for a radix-2 Booth multiplier datapath.
// Issues load / add / sub / shift strobes for N iterations and holds done_o
// until res_ack_i. Define BOOTH_ZERO_SKIP_EN to fold the shift into the
// ARITH cycle whenever the Booth pair calls for no add/sub.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter  int N     = 8,
    localparam int CNT_W = cnt_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             abort_i,
    input  logic             q0_i,
    input  logic             qm1_i,
    output logic             load_o,
    output logic             add_o,
    output logic             sub_o,
    output logic             shift_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic             res_ack_i,
    output logic [CNT_W-1:0] iter_o
);

    state_e           state_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             load_r;
    logic             shift_r;

    op_e              op_s;
    logic             add_s;
    logic             sub_s;
    logic             skip_s;
    logic             is_one_s;
    logic [CNT_W-1:0] iter_s;

    // Booth decode in ARITH; abort suppresses every strobe in its cycle.
    always_comb begin
        op_s   = decode_op(q0_i, qm1_i);
        add_s  = 1'b0;
        sub_s  = 1'b0;
        skip_s = 1'b0;
        if ((state_r == ARITH) && !abort_i) begin
            add_s  = (op_s == ADD);
            sub_s  = (op_s == SUB);
`ifdef BOOTH_ZERO_SKIP_EN
            skip_s = (op_s == NOP);
`else
            skip_s = 1'b0;
`endif
        end else begin
            add_s  = 1'b0;
            sub_s  = 1'b0;
            skip_s = 1'b0;
        end
    end

    // Main FSM; status flags and load/shift strobes are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            load_r  <= 1'b0;
            shift_r <= 1'b0;
        end else if (abort_i) begin
            // Abort also blocks acceptance when already idle.
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            load_r  <= 1'b0;
            shift_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_r <= LOAD;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        load_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    state_r <= ARITH;
                    load_r  <= 1'b0;
                end
                ARITH: begin
`ifdef BOOTH_ZERO_SKIP_EN
                    if (op_s == NOP) begin
                        if (is_one_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ARITH;
                        end
                    end else begin
                        state_r <= SHIFT;
                        shift_r <= 1'b1;
                    end
`else
                    state_r <= SHIFT;
                    shift_r <= 1'b1;
`endif
                end
                SHIFT: begin
                    shift_r <= 1'b0;
                    if (is_one_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ARITH;
                    end
                end
                DONE: begin
                    if (res_ack_i) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    load_r  <= 1'b0;
                    shift_r <= 1'b0;
                end
            endcase
        end
    end

    assign load_o  = load_r & ~abort_i;
    assign shift_o = (shift_r | skip_s) & ~abort_i;
    assign add_o   = add_s;
    assign sub_o   = sub_s;
    assign ready_o = ready_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign iter_o  = iter_s;

    booth_iter_cnt #(
        .W(CNT_W)
    ) u_iter_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_i),
        .load     (load_o),
        .dec      (shift_o),
        .load_val (CNT_W'(N)),
        .cnt      (iter_s),
        .is_one   (is_one_s)
    );

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl (N=8) with a small Booth datapath model.
// Expectations adapt when BOOTH_ZERO_SKIP_EN is defined for the build.
module tb_booth_seq_ctrl;

    localparam int N = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start_i   = 1'b0;
    logic       abort_i   = 1'b0;
    logic       res_ack_i = 1'b0;
    logic       ready_o, load_o, add_o, sub_o, shift_o, busy_o, done_o;
    logic [3:0] iter_o;

    // Datapath model; A carries one guard bit so M = -128 cannot overflow.
    logic [N:0]   a_r   = '0;
    logic [N:0]   m_r   = '0;
    logic [N-1:0] q_r   = '0;
    logic         qm1_r = 1'b0;
    logic [7:0]   mcand_v = 8'd0;
    logic [7:0]   mplr_v  = 8'd0;

    int checks = 0;
    int errors = 0;

    booth_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .ready_o   (ready_o),
        .abort_i   (abort_i),
        .q0_i      (q_r[0]),
        .qm1_i     (qm1_r),
        .load_o    (load_o),
        .add_o     (add_o),
        .sub_o     (sub_o),
        .shift_o   (shift_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .res_ack_i (res_ack_i),
        .iter_o    (iter_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_o) begin
            a_r   <= '0;
            q_r   <= mplr_v;
            qm1_r <= 1'b0;
            m_r   <= {mcand_v[7], mcand_v};
        end else if (add_o) begin
            a_r <= a_r + m_r;
        end else if (sub_o) begin
            a_r <= a_r - m_r;
        end else if (shift_o) begin
            {a_r, q_r, qm1_r} <= {a_r[N], a_r, q_r};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int strobe_count();
        return int'(load_o) + int'(add_o) + int'(sub_o) + int'(shift_o);
    endfunction

    // Latency counts clock edges with the accept edge as edge 1.
    // ops packs 2 bits per ARITH cycle (01 add, 10 sub, 00 none), oldest first.
    task automatic run_mult(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                            input logic [15:0] exp_prod, input int lat_plain, input int lat_skip,
                            input logic [15:0] exp_ops, input int hold);
        int          lat;
        int          nshift;
        logic [15:0] ops;
        logic        seen;
        ops    = 16'h0000;
        nshift = 0;
        seen   = 1'b0;
        @(negedge clk);
        check({tag, "_ready"}, ready_o, 1);
        mcand_v = mc;
        mplr_v  = mp;
        start_i = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_excl"}, (strobe_count() > 1) ? 1 : 0, 0);
            if (shift_o) nshift++;
            if (busy_o && !load_o && !shift_o) ops = {ops[13:0], sub_o, add_o};
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_done"}, seen, 1);
`ifdef BOOTH_ZERO_SKIP_EN
        check({tag, "_lat"}, lat, lat_skip);
`else
        check({tag, "_lat"}, lat, lat_plain);
        check({tag, "_ops"}, ops, exp_ops);
`endif
        check({tag, "_prod"}, {a_r[7:0], q_r}, exp_prod);
        check({tag, "_shifts"}, nshift, 8);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_iter"}, iter_o, 0);
        for (int i = 0; i < hold; i++) begin
            start_i = i[0];
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_done"}, done_o, 1);
            check({tag, "_hold_ready"}, ready_o, 0);
            check({tag, "_hold_strobe"}, strobe_count(), 0);
        end
        // Ack with a simultaneous start: ack wins, start is dropped.
        res_ack_i = 1'b1;
        start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ack_i = 1'b0;
        start_i   = 1'b0;
        check({tag, "_ack_ready"}, ready_o, 1);
        check({tag, "_ack_done"}, done_o, 0);
        check({tag, "_ack_noload"}, load_o, 0);
    endtask

    initial begin
        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready", ready_o, 1);
        check("idle_busy", busy_o, 0);
        check("idle_done", done_o, 0);
        check("idle_strobes", strobe_count(), 0);
        check("idle_iter", iter_o, 0);

        run_mult("m7xm3", 8'd7, 8'hFD, 16'hFFEB, 18, 13, 16'h9800, 10);

        // Abort during idle blocks the accept.
        @(negedge clk);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_idle_noload", load_o, 0);
        check("abort_idle_ready", ready_o, 1);

        // Abort in the third ARITH cycle (an ADD cycle in the plain build).
        mcand_v = 8'd5;
        mplr_v  = 8'h0B;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("abort_load", load_o, 1);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_busy", busy_o, 1);
        abort_i = 1'b1;
        #1;
        check("abort_nostrobe", strobe_count(), 0);
        @(posedge clk);
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_ready", ready_o, 1);
        check("abort_busy_off", busy_o, 0);
        check("abort_iter", iter_o, 0);
        check("abort_after_strobe", strobe_count(), 0);

        run_mult("m5x7", 8'd5, 8'd7, 16'h0023, 18, 12, 16'h8100, 0);
        run_mult("m128x128", 8'h80, 8'h80, 16'h4000, 18, 11, 16'h0002, 0);
        run_mult("m0x7f", 8'h00, 8'h7F, 16'h0000, 18, 12, 16'h8001, 0);
        run_mult("m7fx80", 8'h7F, 8'h80, 16'hC080, 18, 11, 16'h0002, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
